neureka_stream_unpacker: RTL and testbench

Width-down-converter between the streamer's wide load streams (norm/streamin) and the narrow per-word consumers in the engine datapath.
- Sink: one BW-bit beat at a time from the streamer source.
- Source: BW/OUT_WIDTH words of OUT_WIDTH bits, LSB-first, for a programmed total word count.
- Trims the partial last beat and pulses done.
- Sits directly downstream of the streamer `norm_o`/`streamin_o` outputs.

---
 rtl/neureka_stream_unpacker_pkg.sv | 30 +++
 rtl/neureka_stream_unpacker_buffer.sv | 37 +++
 rtl/neureka_stream_unpacker.sv | 143 ++++++++++++++
 tb/tb_neureka_stream_unpacker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/neureka_stream_unpacker_pkg.sv
// Shared types and constants for the NEUREKA wide-to-narrow stream unpacker.
package neureka_stream_unpacker_pkg;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
  localparam int unsigned NEUREKA_UNPACK_RATIO      = NEUREKA_MEM_BANDWIDTH_EXT / 32;
  localparam int unsigned NEUREKA_UNPACK_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } unpacker_state_t;

  typedef struct packed {
    logic                            start;
    logic [NEUREKA_UNPACK_CNT_W-1:0] tot_words;
  } ctrl_unpacker_t;

  typedef struct packed {
    logic                            busy;
    logic                            done;
    logic [NEUREKA_UNPACK_CNT_W-1:0] words_left;
  } flags_unpacker_t;

  // A single-word beat still needs a 1-bit index so the select logic stays uniform.
  function automatic int unsigned unpack_idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/neureka_stream_unpacker_buffer.sv
// Holds one wide beat and presents the word selected by the current index.
module neureka_stream_unpacker_buffer #(
  parameter int unsigned BW        = 256,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [BW-1:0]        data_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [OUT_WIDTH-1:0] word_o
);

  logic [BW-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign word_o = data_q[int'(idx_i) * OUT_WIDTH +: OUT_WIDTH];

endmodule

// File: rtl/neureka_stream_unpacker.sv
// Splits wide streamer beats into LSB-first narrow words for a programmed word count.
module neureka_stream_unpacker
  import neureka_stream_unpacker_pkg::*;
#(
  parameter int unsigned BW        = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = NEUREKA_UNPACK_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   tot_words_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [BW-1:0]          push_data_i,
  output logic                   pop_valid_o,
  input  logic                   pop_ready_i,
  output logic [OUT_WIDTH-1:0]   pop_data_o,
  output logic [OUT_WIDTH/8-1:0] pop_strb_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   words_left_o
);

  localparam int unsigned R     = BW / OUT_WIDTH;
  localparam int unsigned IDX_W = unpack_idx_width(R);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

  unpacker_state_t      state_d, state_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic                 buf_valid_d, buf_valid_q;
  logic [CNT_WIDTH-1:0] words_left_d, words_left_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;

  logic pop_valid, pop_hs, push_ready, push_hs, last_word, wrap;

  assign pop_valid = buf_valid_q & enable_i;
  assign pop_hs    = pop_valid & pop_ready_i;
  assign last_word = (words_left_q == CNT_WIDTH'(1));
  assign wrap      = (idx_q == IDX_LAST);
  // Refill on the wrap handshake keeps one word per cycle across beat boundaries;
  // the final word never pulls another beat. Clear blocks intake so no beat is lost.
  assign push_ready = enable_i & ~clear_i & (state_q == RUN) &
                      (~buf_valid_q | (pop_hs & wrap & ~last_word));
  assign push_hs    = push_valid_i & push_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_valid_d  = buf_valid_q;
    words_left_d = words_left_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (clear_i) begin
      state_d      = IDLE;
      idx_d        = '0;
      buf_valid_d  = 1'b0;
      words_left_d = '0;
      busy_d       = 1'b0;
    end else if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (tot_words_i != '0) begin
              state_d      = RUN;
              words_left_d = tot_words_i;
              busy_d       = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (pop_hs) begin
            words_left_d = words_left_q - CNT_WIDTH'(1);
            if (last_word) begin
              idx_d       = '0;
              buf_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = DONE;
            end else if (wrap) begin
              idx_d       = '0;
              buf_valid_d = push_hs;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (push_hs) begin
            buf_valid_d = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      buf_valid_q  <= 1'b0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_valid_q  <= buf_valid_d;
      words_left_q <= words_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  neureka_stream_unpacker_buffer #(
    .BW        (BW),
    .OUT_WIDTH (OUT_WIDTH),
    .IDX_W     (IDX_W)
  ) i_buffer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .load_i  (push_hs),
    .data_i  (push_data_i),
    .idx_i   (idx_q),
    .word_o  (pop_data_o)
  );

  assign push_ready_o = push_ready;
  assign pop_valid_o  = pop_valid;
  assign pop_strb_o   = '1;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_left_o = words_left_q;

endmodule

// File: tb/tb_neureka_stream_unpacker.sv
// Scoreboard bench for the stream unpacker: expected words come from slicing the offered beats.
module tb_neureka_stream_unpacker;

  localparam int BW = 256;
  localparam int OW = 32;
  localparam int CW = 16;
  localparam int R  = BW / OW;

  logic          clk, rst_n, clear, enable, start;
  logic [CW-1:0] tot_words;
  logic          push_valid, push_ready;
  logic [BW-1:0] push_data;
  logic          pop_valid, pop_ready;
  logic [OW-1:0] pop_data;
  logic [OW/8-1:0] pop_strb;
  logic          busy, done;
  logic [CW-1:0] words_left;

  neureka_stream_unpacker #(.BW(BW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .start_i(start), .tot_words_i(tot_words),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_data_i(push_data),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_data_o(pop_data),
    .pop_strb_o(pop_strb), .busy_o(busy), .done_o(done), .words_left_o(words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] beat_q[$];
  logic [OW-1:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int beats_taken = 0, pop_count = 0, done_cnt = 0, busy_cycles = 0;
  int job_step = 0, rdy_mode = 0;
  logic mon_en = 1'b0, push_hs_seen = 1'b0, last_hs_prev = 1'b0, zero_done_exp = 1'b0;
  logic stall_prev = 1'b0;
  logic [OW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [BW-1:0] seq_beat(input int base);
    logic [BW-1:0] b;
    for (int i = 0; i < R; i++) b[i*OW +: OW] = OW'(base + i);
    return b;
  endfunction

  task automatic drive_push();
    push_valid = (beat_q.size() > 0);
    push_data  = (beat_q.size() > 0) ? beat_q[0] : '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (push_hs_seen) begin
      void'(beat_q.pop_front());
      beats_taken++;
    end
    job_step++;
    case (rdy_mode)
      0:       pop_ready = 1'b1;
      1:       pop_ready = job_step[0];
      2:       pop_ready = 1'($urandom_range(0, 1));
      default: pop_ready = 1'b0;
    endcase
    drive_push();
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      logic          hs, last_next;
      logic [OW-1:0] e;
      check("done_timing", BW'(done), BW'(last_hs_prev | zero_done_exp));
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (busy) check("words_left", BW'(words_left), BW'(exp_q.size()));
      if (!enable) check("enable_low_quiet", BW'({pop_valid, push_ready}), BW'(0));
      if (!busy) check("idle_no_ready", BW'(push_ready), BW'(0));
      if (enable && !clear) begin
        if (stall_prev) begin
          check("stall_valid", BW'(pop_valid), BW'(1));
          check("stall_data", BW'(pop_data), BW'(stall_data));
        end
        stall_prev = pop_valid & ~pop_ready;
        stall_data = pop_data;
      end else if (clear) begin
        stall_prev = 1'b0;
      end
      hs = pop_valid & pop_ready & ~clear;
      last_next = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", BW'(pop_data), BW'(0) - BW'(1));
        end else begin
          e = exp_q.pop_front();
          check("pop_data", BW'(pop_data), BW'(e));
          pop_count++;
          last_next = (exp_q.size() == 0);
        end
      end
      last_hs_prev = last_next;
      push_hs_seen = push_valid & push_ready;
    end
  end

  task automatic run_job(input int tot, input int mode, input int clear_at,
                         input int en_at, input int restart_at, input int exp_busy);
    int need, b0, p0, d0, n, w, max_cyc;
    logic en_done, rs_done;
    need = (tot + R - 1) / R;
    max_cyc = tot * 30 + 100;
    while (beat_q.size() < need) beat_q.push_back(rand_beat());
    drive_push();
    for (int i = 0; i < tot; i++) begin
      logic [BW-1:0] b;
      b = beat_q[i / R];
      exp_q.push_back(b[(i % R) * OW +: OW]);
    end
    b0 = beats_taken; p0 = pop_count; d0 = done_cnt;
    busy_cycles = 0; rdy_mode = mode; job_step = 0;
    en_done = 1'b0; rs_done = 1'b0; n = 0;
    start = 1'b1; tot_words = CW'(tot);
    step();
    start = 1'b0; tot_words = CW'($urandom_range(0, 50));
    while (done_cnt == d0 && n < max_cyc) begin
      w = pop_count - p0;
      if (clear_at >= 0 && w == clear_at) begin
        clear = 1'b1; rdy_mode = 3; pop_ready = 1'b0;
        step();
        clear = 1'b0;
        check("clear_valid", BW'(pop_valid), BW'(0));
        check("clear_busy", BW'(busy), BW'(0));
        check("clear_words_left", BW'(words_left), BW'(0));
        check("clear_beats", BW'(beats_taken - b0), BW'(clear_at / R + 1));
        exp_q.delete();
        rdy_mode = 0;
        return;
      end
      if (en_at >= 0 && w == en_at && !en_done) begin
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1; en_done = 1'b1;
      end
      if (restart_at >= 0 && w == restart_at && !rs_done) begin
        start = 1'b1; tot_words = CW'(5);
        step();
        start = 1'b0; rs_done = 1'b1;
      end
      step();
      n++;
    end
    check("done_seen", BW'(done_cnt - d0), BW'(1));
    check("all_words_out", BW'(exp_q.size()), BW'(0));
    check("beats_taken", BW'(beats_taken - b0), BW'(need));
    if (exp_busy >= 0) check("busy_cycles", BW'(busy_cycles), BW'(exp_busy));
    exp_q.delete();
    rdy_mode = 0;
  endtask

  initial begin
    logic [BW-1:0] third;
    int b0, tot, en;
    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; start = 1'b0; tot_words = '0;
    push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop_valid", BW'(pop_valid), BW'(0));
    check("rst_push_ready", BW'(push_ready), BW'(0));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_done", BW'(done), BW'(0));
    check("rst_words_left", BW'(words_left), BW'(0));
    check("rst_pop_data", BW'(pop_data), BW'(0));
    check("pop_strb", BW'(pop_strb), BW'(4'hF));
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    beat_q.push_back(seq_beat(0));
    run_job(8, 0, -1, -1, -1, 9);

    third = rand_beat();
    beat_q.push_back(seq_beat(0));
    beat_q.push_back(seq_beat(8));
    beat_q.push_back(third);
    run_job(11, 0, -1, -1, -1, 12);
    check("third_beat_left", BW'(beat_q.size()), BW'(1));
    check("third_beat_data", beat_q[0], third);

    run_job(8, 1, -1, -1, -1, 17);

    b0 = beats_taken;
    start = 1'b1; tot_words = '0;
    step();
    start = 1'b0; zero_done_exp = 1'b1;
    check("zero_busy", BW'(busy), BW'(0));
    check("zero_done", BW'(done), BW'(1));
    step();
    zero_done_exp = 1'b0;
    check("zero_done_clr", BW'(done), BW'(0));
    check("zero_beats", BW'(beats_taken - b0), BW'(0));

    run_job(20, 0, 5, -1, -1, -1);
    run_job(4, 0, -1, -1, -1, 5);

    run_job(16, 0, -1, 3, 10, -1);

    for (int k = 0; k < 6; k++) begin
      tot = $urandom_range(1, 40);
      en  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, tot - 1) : -1;
      run_job(tot, 2, -1, en, -1, -1);
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
